// File: rtl/csa_nibble_sequencer_pkg.sv
// Shared constants and types for the nibble-serial carry-select adder sequencer.
package csa_nibble_sequencer_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of the nibble index for a given operand width (never narrower than 1 bit).
    function automatic int unsigned nib_idx_w(input int unsigned width);
        int unsigned n;
        n = width / NIBBLE_W;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/csa_nibble_sequencer_csa4.sv
// 4-bit carry-select adder slice: ripple low pair, upper pair precomputed for both carries.
module csa_nibble_sequencer_csa4
    import csa_nibble_sequencer_pkg::*;
(
    input  logic [NIBBLE_W-1:0] i_a,
    input  logic [NIBBLE_W-1:0] i_b,
    input  logic                i_cin,
    output logic [NIBBLE_W-1:0] o_sum_c,
    output logic                o_cout_c
);

    logic [2:0] w_lo;
    logic [2:0] w_hi0;
    logic [2:0] w_hi1;
    logic [2:0] w_hi;

    // Low pair ripples from the incoming carry; upper pair is computed for both carry values.
    always_comb begin
        w_lo  = {1'b0, i_a[1:0]} + {1'b0, i_b[1:0]} + {2'b00, i_cin};
        w_hi0 = {1'b0, i_a[3:2]} + {1'b0, i_b[3:2]};
        w_hi1 = {1'b0, i_a[3:2]} + {1'b0, i_b[3:2]} + 3'd1;
        w_hi  = w_lo[2] ? w_hi1 : w_hi0;
        o_sum_c  = {w_hi[1:0], w_lo[1:0]};
        o_cout_c = w_hi[2];
    end

endmodule

// File: rtl/csa_nibble_sequencer.sv
// Two-requester wide adder that time-shares one 4-bit carry-select slice, LS nibble first.
module csa_nibble_sequencer
    import csa_nibble_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req0_valid,
    input  logic [WIDTH-1:0] i_req0_a,
    input  logic [WIDTH-1:0] i_req0_b,
    input  logic             i_req0_cin,
    output logic             o_req0_ready_c,
    input  logic             i_req1_valid,
    input  logic [WIDTH-1:0] i_req1_a,
    input  logic [WIDTH-1:0] i_req1_b,
    input  logic             i_req1_cin,
    output logic             o_req1_ready_c,
    output logic             o_resp_valid,
    input  logic             i_resp_ready,
    output logic [WIDTH-1:0] o_resp_s,
    output logic             o_resp_cout,
    output logic             o_resp_id,
    output logic             o_busy
);

    localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
    localparam int unsigned KW      = nib_idx_w(WIDTH);
    localparam int unsigned BW      = KW + 2;

    state_t               r_state;
    logic                 r_last_grant;
    logic [KW-1:0]        r_k;
    logic                 r_carry;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_sum;
    logic                 r_cout;
    logic                 r_id;
    logic                 r_resp_valid;
    logic                 r_busy;

    logic                 w_grant0;
    logic                 w_grant1;
    logic                 w_ready0;
    logic                 w_ready1;
    logic [BW-1:0]        w_base;
    logic [NIBBLE_W-1:0]  w_a_nib;
    logic [NIBBLE_W-1:0]  w_b_nib;
    logic [NIBBLE_W-1:0]  w_slice_s;
    logic                 w_slice_cout;

    // Round-robin grant: a lone requester wins; on a tie the one not granted last wins.
    always_comb begin
        w_grant0 = i_req0_valid & (~i_req1_valid | r_last_grant);
        w_grant1 = i_req1_valid & (~i_req0_valid | ~r_last_grant);
        w_ready0 = ~i_rst & (r_state == ST_IDLE) & w_grant0;
        w_ready1 = ~i_rst & (r_state == ST_IDLE) & w_grant1;
    end

    // Select the current nibble of each captured operand for the shared slice.
    always_comb begin
        w_base  = {r_k, 2'b00};
        w_a_nib = r_a[w_base +: NIBBLE_W];
        w_b_nib = r_b[w_base +: NIBBLE_W];
    end

    csa_nibble_sequencer_csa4 u_slice (
        .i_a      (w_a_nib),
        .i_b      (w_b_nib),
        .i_cin    (r_carry),
        .o_sum_c  (w_slice_s),
        .o_cout_c (w_slice_cout)
    );

    // Sequencer: accept one operation, step the slice once per nibble, hold the result until taken.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_k          <= '0;
            r_carry      <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_sum        <= '0;
            r_cout       <= 1'b0;
            r_id         <= 1'b0;
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_ready0) begin
                        r_a          <= i_req0_a;
                        r_b          <= i_req0_b;
                        r_carry      <= i_req0_cin;
                        r_id         <= 1'b0;
                        r_last_grant <= 1'b0;
                        r_k          <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= ST_ADD;
                    end else if (w_ready1) begin
                        r_a          <= i_req1_a;
                        r_b          <= i_req1_b;
                        r_carry      <= i_req1_cin;
                        r_id         <= 1'b1;
                        r_last_grant <= 1'b1;
                        r_k          <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    r_sum[w_base +: NIBBLE_W] <= w_slice_s;
                    r_carry                   <= w_slice_cout;
                    if (r_k == KW'(NIBBLES - 1)) begin
                        r_k          <= '0;
                        r_cout       <= w_slice_cout;
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_DONE;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                ST_DONE: begin
                    if (i_resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_req0_ready_c = w_ready0;
    assign o_req1_ready_c = w_ready1;
    assign o_resp_valid   = r_resp_valid;
    assign o_resp_s       = r_sum;
    assign o_resp_cout    = r_cout;
    assign o_resp_id      = r_id;
    assign o_busy         = r_busy;

endmodule

// File: tb/tb_csa_nibble_sequencer.sv
// Self-checking bench for csa_nibble_sequencer (WIDTH=16) with an arithmetic reference model.
module tb_csa_nibble_sequencer;

    localparam int unsigned W = 16;

    logic         clk;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_cin, req1_cin;
    logic         rdy0, rdy1;
    logic         resp_valid, resp_ready;
    logic [W-1:0] resp_s;
    logic         resp_cout, resp_id, busy;

    int n_checks = 0;
    int n_fail   = 0;

    csa_nibble_sequencer #(.WIDTH(W)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req0_valid   (req0_valid),
        .i_req0_a       (req0_a),
        .i_req0_b       (req0_b),
        .i_req0_cin     (req0_cin),
        .o_req0_ready_c (rdy0),
        .i_req1_valid   (req1_valid),
        .i_req1_a       (req1_a),
        .i_req1_b       (req1_b),
        .i_req1_cin     (req1_cin),
        .o_req1_ready_c (rdy1),
        .o_resp_valid   (resp_valid),
        .i_resp_ready   (resp_ready),
        .o_resp_s       (resp_s),
        .o_resp_cout    (resp_cout),
        .o_resp_id      (resp_id),
        .o_busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rdy0"},  32'(rdy0), 0);
        check({tag, "_rdy1"},  32'(rdy1), 0);
        check({tag, "_valid"}, 32'(resp_valid), 0);
        check({tag, "_s"},     32'(resp_s), 0);
        check({tag, "_cout"},  32'(resp_cout), 0);
        check({tag, "_id"},    32'(resp_id), 0);
        check({tag, "_busy"},  32'(busy), 0);
    endtask

    task automatic drive_req(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic cin, input logic v);
        if (id == 1'b0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_cin = cin;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_cin = cin;
        end
    endtask

    // Present a request, wait (bounded) for its Ready, return after the accept edge.
    task automatic issue(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, output int waited);
        bit seen;
        seen   = 1'b0;
        waited = 0;
        @(negedge clk);
        drive_req(id, a, b, cin, 1'b1);
        for (int i = 0; i < 16; i++) begin
            #1;
            if ((id ? rdy1 : rdy0) === 1'b1) begin
                seen = 1'b1;
                break;
            end
            waited++;
            @(negedge clk);
        end
        check("accept_seen", 32'(seen), 1);
        check("ready_other_low", 32'(id ? rdy0 : rdy1), 0);
        @(posedge clk);
        #1;
        drive_req(id, '0, '0, 1'b0, 1'b0);
    endtask

    // Follow an accepted operation through ADD and DONE, with optional backpressure.
    task automatic finish_op(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic cin, input int hold);
        logic [W:0] exp;
        exp = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            check("valid_latency", 32'(resp_valid), (k == 4) ? 1 : 0);
            check("busy_active", 32'(busy), 1);
        end
        check("resp_s", 32'(resp_s), 32'(exp[W-1:0]));
        check("resp_cout", 32'(resp_cout), 32'(exp[W]));
        check("resp_id", 32'(resp_id), 32'(id));
        if (hold > 0) drive_req(!id, 16'hAAAA, 16'h5555, 1'b0, 1'b1);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            #1;
            check("hold_valid", 32'(resp_valid), 1);
            check("hold_s", 32'(resp_s), 32'(exp[W-1:0]));
            check("hold_cout", 32'(resp_cout), 32'(exp[W]));
            check("hold_id", 32'(resp_id), 32'(id));
            check("hold_busy", 32'(busy), 1);
            check("hold_rdy", 32'({rdy1, rdy0}), 0);
        end
        drive_req(!id, '0, '0, 1'b0, 1'b0);
        resp_ready = 1'b1;
        @(negedge clk);
        check("xfer_valid_low", 32'(resp_valid), 0);
        check("xfer_busy_low", 32'(busy), 0);
        resp_ready = 1'b0;
    endtask

    initial begin
        logic [W-1:0] a, b;
        logic         cin;
        bit           id;
        bit           model_last;
        bit           exp_id;
        bit           found;
        int           waited;
        logic [W:0]   exp;

        rst = 1'b1;
        resp_ready = 1'b0;
        drive_req(1'b0, '0, '0, 1'b0, 1'b0);
        drive_req(1'b1, '0, '0, 1'b0, 1'b0);
        #1;
        check_zero("reset");

        // Round robin with both requesters valid from reset.
        @(negedge clk);
        drive_req(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
        drive_req(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
        #1;
        check_zero("reset_valid_high");
        @(negedge clk);
        rst = 1'b0;
        resp_ready = 1'b1;
        model_last = 1'b1;
        for (int op = 0; op < 4; op++) begin
            exp_id = !model_last;
            model_last = exp_id;
            found = 1'b0;
            for (int i = 0; i < 16; i++) begin
                #1;
                if ((rdy0 | rdy1) === 1'b1) begin
                    found = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            check("rr_found", 32'(found), 1);
            check("rr_onehot", 32'(rdy0) + 32'(rdy1), 1);
            check("rr_order", 32'(rdy1), 32'(exp_id));
            exp = exp_id ? ({1'b0, req1_a} + {1'b0, req1_b} + (W+1)'(req1_cin))
                         : ({1'b0, req0_a} + {1'b0, req0_b} + (W+1)'(req0_cin));
            @(posedge clk);
            #1;
            drive_req(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
            drive_req(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
            for (int j = 0; j <= 4; j++) begin
                @(negedge clk);
                check("rr_no_extra_ready", 32'({rdy1, rdy0}), 0);
            end
            check("rr_valid", 32'(resp_valid), 1);
            check("rr_sum", 32'({resp_cout, resp_s}), 32'(exp));
            check("rr_id", 32'(resp_id), 32'(exp_id));
        end
        drive_req(1'b0, '0, '0, 1'b0, 1'b0);
        drive_req(1'b1, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        check("rr_drained", 32'(resp_valid), 0);
        resp_ready = 1'b0;

        // Directed sums, including carries that cross every nibble.
        issue(1'b0, 16'h1234, 16'h4321, 1'b0, waited);
        finish_op(1'b0, 16'h1234, 16'h4321, 1'b0, 0);
        check("dir_5555", 32'(resp_s), 32'h5555);
        issue(1'b1, 16'hFFFF, 16'h0000, 1'b1, waited);
        finish_op(1'b1, 16'hFFFF, 16'h0000, 1'b1, 0);
        issue(1'b1, 16'h8000, 16'h8000, 1'b0, waited);
        finish_op(1'b1, 16'h8000, 16'h8000, 1'b0, 0);

        // Backpressure: response held three cycles.
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        issue(1'b0, a, b, cin, waited);
        finish_op(1'b0, a, b, cin, 3);

        // Reset during the second ADD cycle discards the operation.
        issue(1'b0, 16'h0F0F, 16'h0101, 1'b1, waited);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_reset_no_resp", 32'(resp_valid), 0);
        end
        issue(1'b0, 16'h0001, 16'h0001, 1'b0, waited);
        finish_op(1'b0, 16'h0001, 16'h0001, 1'b0, 0);
        check("post_reset_sum", 32'(resp_s), 32'h0002);

        // Requester 1 alone, back to back.
        for (int n = 0; n < 3; n++) begin
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            issue(1'b1, a, b, cin, waited);
            check("solo_req1_nowait", 32'(waited), 0);
            finish_op(1'b1, a, b, cin, 0);
        end

        // Random sweep against A+B+Cin.
        for (int n = 0; n < 12; n++) begin
            id = 1'($urandom); a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            issue(id, a, b, cin, waited);
            finish_op(id, a, b, cin, int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
